// File: rtl/iob_vga_gen.sv
// rtl/iob_vga_gen.sv - VGA timing generator with pixel fetch handshake and underrun flag
module iob_vga_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4,
    parameter int COLOR_W   = 4,
    parameter int ADDR_W    = 19,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [3*COLOR_W-1:0]   pixel,
    input  logic                   pixel_valid,
    input  logic                   clr_underrun,
    output logic                   pixel_req,
    output logic [ADDR_W-1:0]      pixel_addr,
    output logic                   h_sync,
    output logic                   v_sync,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   frame_start,
    output logic                   underrun
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_VISIBLE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_VISIBLE + V_FP;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int D_W     = $clog2(CLK_DIV);

    localparam logic [D_W-1:0] DIV_LAST    = D_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_SYNC_END  = H_W'(H_SYNC);
    localparam logic [H_W-1:0] H_VIS_FIRST = H_W'(H_SYNC + H_BP);
    localparam logic [H_W-1:0] H_VIS_LAST  = H_W'(H_SYNC + H_BP + H_VISIBLE - 1);
    localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_SYNC_END  = V_W'(V_SYNC);
    localparam logic [V_W-1:0] V_VIS_FIRST = V_W'(V_SYNC + V_BP);
    localparam logic [V_W-1:0] V_VIS_LAST  = V_W'(V_SYNC + V_BP + V_VISIBLE - 1);

    localparam logic [ADDR_W-1:0] A_H_VIS   = ADDR_W'(H_VISIBLE);
    localparam logic [ADDR_W-1:0] A_H_FIRST = ADDR_W'(H_SYNC + H_BP);
    localparam logic [ADDR_W-1:0] A_V_FIRST = ADDR_W'(V_SYNC + V_BP);

    localparam logic HS_ACT = 1'(HS_POL);
    localparam logic VS_ACT = 1'(VS_POL);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [D_W-1:0]    div_cnt;
    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;
    logic [H_W-1:0]    h_nxt;
    logic [V_W-1:0]    v_nxt;
    logic              h_wrap;
    logic              pix_en;
    logic              advance;
    logic              vis_cur;
    logic              vis_nxt;
    logic              underrun_set;
    logic [ADDR_W-1:0] addr_nxt;

    assign pix_en = (div_cnt == DIV_LAST);

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? '0 : h_cnt + H_W'(1);
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
        end
    end

    assign vis_cur = (h_cnt >= H_VIS_FIRST) && (h_cnt <= H_VIS_LAST) &&
                     (v_cnt >= V_VIS_FIRST) && (v_cnt <= V_VIS_LAST);
    assign vis_nxt = (h_nxt >= H_VIS_FIRST) && (h_nxt <= H_VIS_LAST) &&
                     (v_nxt >= V_VIS_FIRST) && (v_nxt <= V_VIS_LAST);

    assign addr_nxt = (ADDR_W'(v_nxt) - A_V_FIRST) * A_H_VIS + (ADDR_W'(h_nxt) - A_H_FIRST);

    // A running frame only stops when it wraps back to the origin with en low.
    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pix_en && en) begin
                    advance   = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (pix_en) begin
                    advance = 1'b1;
                    if ((h_nxt == '0) && (v_nxt == '0) && !en) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign underrun_set = advance && vis_cur && !pixel_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            pixel_addr  <= '0;
            pixel_req   <= 1'b0;
            h_sync      <= ~HS_ACT;
            v_sync      <= ~VS_ACT;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= pix_en ? '0 : div_cnt + D_W'(1);
            pixel_req   <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= underrun_set | (underrun & ~clr_underrun);

            if (advance) begin
                h_cnt       <= h_nxt;
                v_cnt       <= v_nxt;
                h_sync      <= (h_cnt < H_SYNC_END) ? HS_ACT : ~HS_ACT;
                v_sync      <= (v_cnt < V_SYNC_END) ? VS_ACT : ~VS_ACT;
                frame_start <= (h_cnt == '0) && (v_cnt == '0);
                if (vis_cur && pixel_valid) begin
                    {red, green, blue} <= pixel;
                end else begin
                    {red, green, blue} <= '0;
                end
                // Fetch for the slot now being entered; sampled at the following pix_en.
                if (vis_nxt && (state_nxt == S_RUN)) begin
                    pixel_req  <= 1'b1;
                    pixel_addr <= addr_nxt;
                end
            end else if (pix_en) begin
                h_sync             <= ~HS_ACT;
                v_sync             <= ~VS_ACT;
                {red, green, blue} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_iob_vga_gen.sv
// tb/tb_iob_vga_gen.sv - self-checking bench for iob_vga_gen on a small raster
module tb_iob_vga_gen;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int DIV = 3, CW = 4, AW = 19, HSP = 0, VSP = 1;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int TOT = HT * VT;
    localparam int NPIX = HV * VV;
    localparam bit HS_ACT = (HSP != 0);
    localparam bit VS_ACT = (VSP != 0);

    logic clk = 1'b0;
    logic rst, en, pixel_valid, clr_underrun;
    logic [3*CW-1:0] pixel;
    logic pixel_req, h_sync, v_sync, frame_start, underrun;
    logic [AW-1:0] pixel_addr;
    logic [CW-1:0] red, green, blue;

    always #5 clk = ~clk;

    iob_vga_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV), .COLOR_W(CW), .ADDR_W(AW), .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pixel(pixel), .pixel_valid(pixel_valid),
        .clr_underrun(clr_underrun), .pixel_req(pixel_req), .pixel_addr(pixel_addr),
        .h_sync(h_sync), .v_sync(v_sync), .red(red), .green(green), .blue(blue),
        .frame_start(frame_start), .underrun(underrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    logic [11:0] mem [NPIX];
    bit rand_drop = 0;
    bit force_arm = 0;

    function automatic bit vis(input int s);
        int h = s % HT;
        int v = s / HT;
        return (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
    endfunction

    function automatic int addr_of(input int s);
        return (s / HT - (VS + VB)) * HV + (s % HT - (HS + HB));
    endfunction

    // Reference: frame position is a single slot index 0..TOT-1 advanced once per pixel period.
    int m_edge, m_slot;
    bit m_run, model_ok = 0;
    logic e_hs, e_vs, e_req, e_fs, e_und;
    logic [11:0] e_rgb;
    logic [AW-1:0] e_addr;

    always @(posedge clk) begin : ref_model
        int s, slot, edge_n;
        bit set, run;
        logic hs, vs, fs, req;
        logic [11:0] rgb;
        logic [AW-1:0] addr;
        if (!rst) begin
            m_edge <= 0; m_slot <= 0; m_run <= 0;
            e_hs <= !HS_ACT; e_vs <= !VS_ACT; e_rgb <= '0; e_req <= 0;
            e_addr <= '0; e_fs <= 0; e_und <= 0; model_ok <= 1;
        end else begin
            edge_n = m_edge + 1; slot = m_slot; run = m_run;
            hs = e_hs; vs = e_vs; rgb = e_rgb; addr = e_addr;
            fs = 0; req = 0; set = 0;
            if (edge_n % DIV == 0) begin
                if (run || en) begin
                    s = slot;
                    hs = (s % HT < HS) ? HS_ACT : !HS_ACT;
                    vs = (s / HT < VS) ? VS_ACT : !VS_ACT;
                    fs = (s == 0);
                    rgb = '0;
                    if (vis(s)) begin
                        if (pixel_valid) rgb = mem[addr_of(s)];
                        else set = 1;
                    end
                    slot = (s + 1) % TOT;
                    run = !(slot == 0 && !en);
                    if (run && vis(slot)) begin
                        req = 1;
                        addr = AW'(addr_of(slot));
                    end
                end else begin
                    hs = !HS_ACT; vs = !VS_ACT; rgb = '0;
                end
            end
            m_edge <= edge_n; m_slot <= slot; m_run <= run;
            e_hs <= hs; e_vs <= vs; e_rgb <= rgb; e_req <= req; e_addr <= addr; e_fs <= fs;
            e_und <= set || (e_und && !clr_underrun);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("h_sync", h_sync, e_hs);
            check("v_sync", v_sync, e_vs);
            check("rgb", {red, green, blue}, e_rgb);
            check("pixel_req", pixel_req, e_req);
            check("pixel_addr", pixel_addr, e_addr);
            check("frame_start", frame_start, e_fs);
            check("underrun", underrun, e_und);
        end
    end

    int cyc = 0;
    bit mon_on = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b0;
    int req_q[$], hs_fall_q[$], hs_rise_q[$], vs_rise_q[$], vs_fall_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        hs_prev <= h_sync;
        vs_prev <= v_sync;
        if (mon_on) begin
            if (pixel_req) req_q.push_back(int'(pixel_addr));
            if (hs_prev && !h_sync) hs_fall_q.push_back(cyc);
            if (!hs_prev && h_sync) hs_rise_q.push_back(cyc);
            if (!vs_prev && v_sync) vs_rise_q.push_back(cyc);
            if (vs_prev && !v_sync) vs_fall_q.push_back(cyc);
        end
    end

    // Memory responder: garbage until a random point inside the latency budget.
    initial begin : driver
        int dly, a;
        bit drop, pend;
        pend = 0; dly = 0; a = 0; drop = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 0;
            end else if (pixel_req) begin
                a = int'(pixel_addr);
                dly = $urandom_range(0, DIV - 1);
                drop = rand_drop && ($urandom_range(0, 5) == 0);
                if (force_arm && a == 5) begin
                    drop = 1;
                    force_arm = 0;
                end
                pend = 1;
                pixel = 12'($urandom);
                pixel_valid = 0;
            end
            if (pend) begin
                if (dly == 0) begin
                    pixel = (a < NPIX) ? mem[a] : 12'hfff;
                    pixel_valid = !drop;
                    pend = 0;
                end else begin
                    dly--;
                end
            end
        end
    end

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 50);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n, nreq, nfs;
        bit got;
        rst = 0; en = 0; pixel = '0; pixel_valid = 0; clr_underrun = 0;
        for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
        repeat (4) @(negedge clk);
        check("rst_h_sync", h_sync, 1);
        check("rst_v_sync", v_sync, 0);
        check("rst_rgb", {red, green, blue}, 0);
        check("rst_req", pixel_req, 0);
        check("rst_addr", pixel_addr, 0);
        check("rst_fs", frame_start, 0);
        check("rst_underrun", underrun, 0);

        en = 1; rst = 1; mon_on = 1;
        wait_fs(n);
        check("first_fs_delay", n, DIV);
        repeat (2 * TOT * DIV) @(negedge clk);
        mon_on = 0;
        check("reqs_two_frames", req_q.size(), 2 * NPIX);
        for (int i = 0; i < req_q.size(); i++) check("addr_seq", req_q[i], i % NPIX);
        check("hs_edges_seen", (hs_fall_q.size() >= 2) && (hs_rise_q.size() >= 1), 1);
        check("vs_edges_seen", (vs_rise_q.size() >= 2) && (vs_fall_q.size() >= 1), 1);
        if (hs_fall_q.size() >= 2 && hs_rise_q.size() >= 1) begin
            check("hs_period", hs_fall_q[1] - hs_fall_q[0], HT * DIV);
            check("hs_low", hs_rise_q[0] - hs_fall_q[0], HS * DIV);
        end
        if (vs_rise_q.size() >= 2 && vs_fall_q.size() >= 1) begin
            check("vs_period", vs_rise_q[1] - vs_rise_q[0], TOT * DIV);
            check("vs_high", vs_fall_q[0] - vs_rise_q[0], HT * VS * DIV);
        end
        check("no_underrun", underrun, 0);

        force_arm = 1;
        n = 0;
        while (!underrun && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("underrun_set_seen", underrun, 1);
        check("drop_slot_rgb", {red, green, blue}, 0);
        repeat (30) @(negedge clk);
        check("underrun_sticky", underrun, 1);
        clr_underrun = 1;
        @(negedge clk);
        clr_underrun = 0;
        check("underrun_cleared", underrun, 0);

        rand_drop = 1;
        repeat (3 * TOT * DIV) begin
            @(negedge clk);
            clr_underrun = ($urandom_range(0, 15) == 0);
        end
        clr_underrun = 0;
        rand_drop = 0;

        repeat ($urandom_range(10, 120)) @(negedge clk);
        en = 0;
        repeat (TOT * DIV + 10) @(negedge clk);
        check("halt_last_addr", pixel_addr, NPIX - 1);
        nreq = 0; nfs = 0;
        repeat (100) begin
            @(negedge clk);
            if (pixel_req) nreq++;
            if (frame_start) nfs++;
        end
        check("halt_no_req", nreq, 0);
        check("halt_no_fs", nfs, 0);
        check("halt_h_sync", h_sync, 1);
        check("halt_v_sync", v_sync, 0);
        check("halt_rgb", {red, green, blue}, 0);

        en = 1;
        wait_fs(n);
        check("restart_fs_in_div", n <= DIV, 1);
        got = 0; n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (pixel_req) got = 1;
        end
        check("restart_req_seen", got, 1);
        check("restart_addr", pixel_addr, 0);

        rand_drop = 1;
        repeat (TOT * DIV / 2) @(negedge clk);
        got = 0; n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (pixel_req) got = 1;
        end
        check("pre_rst_req_seen", got, 1);
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("midrst_h_sync", h_sync, 1);
        check("midrst_v_sync", v_sync, 0);
        check("midrst_rgb", {red, green, blue}, 0);
        check("midrst_req", pixel_req, 0);
        check("midrst_addr", pixel_addr, 0);
        check("midrst_fs", frame_start, 0);
        check("midrst_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        wait_fs(n);
        check("post_rst_fs_delay", n, DIV);
        repeat (2 * TOT * DIV) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
